// File: rtl/onehot_decoder_seq.sv
// Registered N-to-2^N one-hot decoder with enable, auto-scan and scan load.
// DECODE drives the select lines straight from d. SCAN walks the active line
// around the ring, one step every PERIOD cycles. wrap pulses on the ring seam.
module onehot_decoder_seq #(
  parameter int N      = 2,
  parameter int PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 dir,
  input  logic                 load,
  input  logic [N-1:0]         d,
  output logic [(1<<N)-1:0]    y,
  output logic [N-1:0]         idx,
  output logic                 wrap
);

  localparam int W  = 1 << N;
  localparam int PW = (PERIOD <= 2) ? 1 : $clog2(PERIOD);
  localparam logic [PW-1:0] PMAX = PW'(PERIOD - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_pre;
  logic [W-1:0]  r_y;
  logic [N-1:0]  r_idx;
  logic          r_wrap;

  logic [1:0]    w_state_nxt;
  logic [PW-1:0] w_pre_nxt;
  logic [W-1:0]  w_y_nxt;
  logic [N-1:0]  w_idx_nxt;
  logic          w_wrap_nxt;

  logic [W-1:0]  w_one;
  logic [N-1:0]  w_step_idx;
  logic          w_step_wrap;

  assign w_one       = {{(W-1){1'b0}}, 1'b1};
  // Neighbour index in the chosen direction; the seam is crossed when the
  // current index sits at the end of the ring we are moving away from.
  assign w_step_idx  = dir ? (r_idx - N'(1)) : (r_idx + N'(1));
  assign w_step_wrap = dir ? (r_idx == '0) : (r_idx == '1);

  // Next-state selection: the mode is taken from this cycle's inputs, while
  // the registered state only tells us whether SCAN has just been entered.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_pre_nxt   = '0;
    w_y_nxt     = '0;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = 1'b0;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else if (!mode) begin
      w_state_nxt = S_DECODE;
      w_idx_nxt   = d;
      w_y_nxt     = w_one << d;
    end else begin
      w_state_nxt = S_SCAN;
      if (load) begin
        // load beats both the entry cycle and a step due this cycle
        w_idx_nxt = d;
        w_y_nxt   = w_one << d;
      end else if (r_state != S_SCAN) begin
        // fresh entry: show the held index, restart the prescaler, no step
        w_y_nxt   = w_one << r_idx;
      end else if (r_pre == PMAX) begin
        w_idx_nxt  = w_step_idx;
        w_y_nxt    = w_one << w_step_idx;
        w_wrap_nxt = w_step_wrap;
      end else begin
        w_pre_nxt = r_pre + PW'(1);
        w_y_nxt   = r_y;
      end
    end
  end

  // Register everything; async reset clears outputs, index and prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_y     <= w_y_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: directed scenarios plus random traffic on an
// N=2/PERIOD=4 instance checked every cycle against a behavioural model, and
// a directed walk on an N=3/PERIOD=1 instance.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, dir, load;
  logic [1:0] d;
  logic [3:0] y;
  logic [1:0] idx;
  logic       wrap;

  logic       en2, mode2;
  logic [2:0] d2;
  logic [7:0] y2;
  logic [2:0] idx2;
  logic       wrap2;

  int checks   = 0;
  int failures = 0;
  bit run_chk  = 0;

  // behavioural model of the N=2, PERIOD=4 instance
  int m_idx, m_age;
  bit m_on, m_wrap, m_in_scan;
  localparam int MP = 4;
  localparam int MR = 4;

  onehot_decoder_seq #(.N(2), .PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .load(load),
    .d(d), .y(y), .idx(idx), .wrap(wrap));

  onehot_decoder_seq #(.N(3), .PERIOD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .dir(1'b0), .load(1'b0),
    .d(d2), .y(y2), .idx(idx2), .wrap(wrap2));

  always #5 clk = ~clk;

  task automatic ck(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_age = 0; m_on = 0; m_wrap = 0; m_in_scan = 0;
  endtask

  // One clock of the model, from the inputs as seen at the rising edge.
  task automatic model_step();
    m_wrap = 0;
    if (!en) begin
      m_on = 0; m_in_scan = 0;
    end else if (!mode) begin
      m_on = 1; m_idx = int'(d); m_in_scan = 0;
    end else begin
      m_on = 1;
      if (load) begin
        m_idx = int'(d); m_age = 0;
      end else if (!m_in_scan) begin
        m_age = 0;
      end else begin
        m_age++;
        if (m_age == MP) begin
          m_age = 0;
          if (dir) begin
            m_wrap = (m_idx == 0);
            m_idx  = (m_idx + MR - 1) % MR;
          end else begin
            m_wrap = (m_idx == MR - 1);
            m_idx  = (m_idx + 1) % MR;
          end
        end
      end
      m_in_scan = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit e, input bit m, input bit dr, input bit ld, input int dv);
    en = e; mode = m; dir = dr; load = ld; d = 2'(dv);
  endtask

  // Per-cycle comparison of the main instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (run_chk) begin
        ck("model_y",    32'(y),    m_on ? (32'd1 << m_idx) : 32'd0);
        ck("model_idx",  32'(idx),  32'(m_idx));
        ck("model_wrap", 32'(wrap), 32'(m_wrap));
      end
    end
  end

  initial begin
    logic [3:0] dec_tab [4];
    dec_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    en2 = 0; mode2 = 0; d2 = '0;
    model_reset();
    #2;
    ck("rst_y",    32'(y),    32'd0);
    ck("rst_idx",  32'(idx),  32'd0);
    ck("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk = 1;

    // plain decode of every select value
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, k);
      tick();
      ck("dec_y",    32'(y),    32'(dec_tab[k]));
      ck("dec_idx",  32'(idx),  32'(k));
      ck("dec_wrap", 32'(wrap), 32'd0);
    end

    // upward scan from 0 around the full ring
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i <= 16; i++) begin
      tick();
      ck("scan_up_y",    32'(y),    32'd1 << ((i / 4) % 4));
      ck("scan_up_wrap", 32'(wrap), 32'(i == 16));
    end

    // downward scan from 0 wraps on the first step
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i == 4) begin
        ck("scan_dn_y1",    32'(y),    32'b1000);
        ck("scan_dn_idx1",  32'(idx),  32'd3);
        ck("scan_dn_wrap1", 32'(wrap), 32'd1);
      end
      if (i == 5) ck("scan_dn_wrap_once", 32'(wrap), 32'd0);
      if (i == 8) begin
        ck("scan_dn_y2",    32'(y),    32'b0100);
        ck("scan_dn_wrap2", 32'(wrap), 32'd0);
      end
    end

    // load on the cycle a step from 0 is due
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(1, 1, 0, 1, 2); tick();
    ck("load_y",    32'(y),    32'b0100);
    ck("load_idx",  32'(idx),  32'd2);
    ck("load_wrap", 32'(wrap), 32'd0);
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    ck("load_hold_idx", 32'(idx), 32'd2);
    tick();
    ck("load_next_idx", 32'(idx), 32'd3);
    ck("load_next_y",   32'(y),   32'b1000);

    // enable dropped mid-scan keeps the index, re-entry resumes from it
    drive(1, 0, 0, 0, 2); tick();
    drive(1, 1, 0, 0, 0); tick(); tick();
    drive(0, 1, 0, 0, 0); tick();
    ck("blank_y",   32'(y),   32'd0);
    ck("blank_idx", 32'(idx), 32'd2);
    drive(1, 1, 0, 0, 0); tick();
    ck("reen_y", 32'(y), 32'b0100);
    for (int i = 0; i < 3; i++) tick();
    ck("reen_hold_idx", 32'(idx), 32'd2);
    tick();
    ck("reen_step_idx", 32'(idx), 32'd3);

    // asynchronous reset between edges while showing 1000
    drive(1, 0, 0, 0, 3); tick();
    drive(1, 1, 0, 0, 0); tick();
    ck("pre_arst_y", 32'(y), 32'b1000);
    #2 rst_n = 1'b0;
    #1;
    ck("arst_y",    32'(y),    32'd0);
    ck("arst_idx",  32'(idx),  32'd0);
    ck("arst_wrap", 32'(wrap), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    ck("post_arst_y", 32'(y), 32'b0001);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 3)));
      tick();
    end
    drive(0, 0, 0, 0, 0);

    // N=3, PERIOD=1: steps every cycle, wrap on 7 -> 0
    en2 = 1; mode2 = 0; d2 = 3'd0; tick();
    mode2 = 1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      ck("walk8_y",    32'(y2),    32'd1 << (i % 8));
      ck("walk8_idx",  32'(idx2),  32'(i % 8));
      ck("walk8_wrap", 32'(wrap2), 32'(i == 8));
    end

    run_chk = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
